// File: rtl/sfu_acc_ctrl_pkg.sv
// Shared definitions for the SFU accumulate/ReLU sequencer: FSM states,
// the default kernel tap count, and the read and SFU pipeline depths.
package sfu_acc_ctrl_pkg;

  localparam int TAPS_DEFAULT = 9;
  localparam int RD_LAT       = 1;
  localparam int SFU_LAT      = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_GAP,
    S_FLUSH
  } state_e;

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register with synchronous reset, used to align
// control strobes with the read-data and SFU pipelines.
module ctrl_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every stage is cleared, so no strobe already in flight can
      // fire after reset; this array is tiny and is never an SRAM.
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sfu_acc_ctrl.sv
// Sequencer that streams the tap partial sums of each output pixel from
// psum SRAM into the SFU and writes the ReLU result to output SRAM.
module sfu_acc_ctrl
  import sfu_acc_ctrl_pkg::*;
#(
  parameter int TAPS    = TAPS_DEFAULT,
  parameter int ADDR_BW = 11,
  parameter int OUT_BW  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [OUT_BW-1:0]  cfg_n_out,
  output logic               busy,
  output logic               done,
  output logic               psum_ren,
  output logic [ADDR_BW-1:0] psum_raddr,
  output logic               acc,
  output logic               out_wen,
  output logic [OUT_BW-1:0]  out_waddr
);

  localparam int            KW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [OUT_BW-1:0]  o_q, o_d;
  logic [OUT_BW-1:0]  n_out_q, n_out_d;
  logic [ADDR_BW-1:0] addr_q, addr_d;
  logic               flush_q, flush_d;
  logic               done_q, done_d;
  logic [OUT_BW:0]    wr_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      o_q     <= '0;
      n_out_q <= '0;
      addr_q  <= '0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      k_q     <= k_d;
      o_q     <= o_d;
      n_out_q <= n_out_d;
      addr_q  <= addr_d;
      flush_q <= flush_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first, so no path leaves a
    // variable unassigned and infers a latch.
    state_d = state_q;
    k_d     = k_q;
    o_d     = o_q;
    n_out_d = n_out_q;
    addr_d  = addr_q;
    flush_d = flush_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_n_out != '0) begin
            state_d = S_READ;
            n_out_d = cfg_n_out;
            k_d     = '0;
            o_d     = '0;
            addr_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (k_q == K_LAST) begin
          state_d = S_GAP;
        end else begin
          k_d    = k_q + KW'(1);
          addr_d = addr_q + ADDR_BW'(n_out_q);
        end
      end
      S_GAP: begin
        if (o_q != n_out_q - OUT_BW'(1)) begin
          state_d = S_READ;
          o_d     = o_q + OUT_BW'(1);
          k_d     = '0;
          addr_d  = ADDR_BW'(o_d);
        end else begin
          state_d = S_FLUSH;
          flush_d = 1'b0;
        end
      end
      S_FLUSH: begin
        // Two cycles let the last ReLU result reach output SRAM.
        if (flush_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign psum_ren   = (state_q == S_READ);
  assign psum_raddr = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

  ctrl_delay_line #(
    .WIDTH (1),
    .DEPTH (RD_LAT)
  ) u_acc_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   (psum_ren),
    .q_o   (acc)
  );

  ctrl_delay_line #(
    .WIDTH (OUT_BW + 1),
    .DEPTH (RD_LAT + SFU_LAT)
  ) u_wr_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   ({state_q == S_GAP, o_q}),
    .q_o   (wr_pipe)
  );

  assign out_wen   = wr_pipe[OUT_BW];
  assign out_waddr = wr_pipe[OUT_BW-1:0];

endmodule

// File: tb/tb_sfu_acc_ctrl.sv
// Bench for sfu_acc_ctrl: psum SRAM and SFU models around the DUT, cycle
// timing checked against closed-form schedules, results against a golden sum.
module tb_sfu_acc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  cfg_n_out = '0;
  logic        busy, done, psum_ren, acc, out_wen;
  logic [10:0] psum_raddr;
  logic [4:0]  out_waddr;

  logic        start8 = 1'b0;
  logic [4:0]  cfg8 = '0;
  logic        busy8, done8, ren8, acc8, wen8;
  logic [7:0]  raddr8;
  logic [4:0]  waddr8;

  logic [15:0] psum_mem [2048];
  logic [15:0] psum_dout = '0;
  logic [15:0] sfu_sum, sfp_out;
  logic [15:0] got [32];
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt;

  always #5 clk = ~clk;

  sfu_acc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_n_out  (cfg_n_out),
    .busy       (busy),
    .done       (done),
    .psum_ren   (psum_ren),
    .psum_raddr (psum_raddr),
    .acc        (acc),
    .out_wen    (out_wen),
    .out_waddr  (out_waddr)
  );

  sfu_acc_ctrl #(.ADDR_BW(8)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .start      (start8),
    .cfg_n_out  (cfg8),
    .busy       (busy8),
    .done       (done8),
    .psum_ren   (ren8),
    .psum_raddr (raddr8),
    .acc        (acc8),
    .out_wen    (wen8),
    .out_waddr  (waddr8)
  );

  // psum SRAM with one cycle of read latency
  always @(posedge clk) begin
    if (psum_ren) psum_dout <= psum_mem[psum_raddr];
  end

  // SFU: accumulate while acc is high; an acc=0 cycle latches ReLU and clears
  always @(posedge clk) begin
    if (reset) begin
      sfu_sum <= '0;
      sfp_out <= '0;
    end else if (acc) begin
      sfu_sum <= sfu_sum + psum_dout;
    end else begin
      sfp_out <= sfu_sum[15] ? 16'h0000 : sfu_sum;
      sfu_sum <= '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] golden(input int n, input int o);
    int s;
    s = 0;
    for (int k = 0; k < 9; k++) s += int'(psum_mem[(k * n + o) % 2048]);
    s = s % 65536;
    return (s >= 32768) ? 16'h0000 : 16'(s);
  endfunction

  task automatic run_pass(input int n, input int extra_start_at, input int rst_at, input string tag);
    logic in_rst, e_ren, e_acc, e_wen, e_busy, e_done;
    wr_cnt = 0;
    for (int i = 0; i < 32; i++) got[i] = 16'hDEAD;
    start = 1'b1;
    cfg_n_out = 5'(n);
    @(posedge clk); #1;
    start = 1'b0;
    cfg_n_out = 5'($urandom);
    for (int c = 0; c <= 10 * n + 4; c++) begin
      start = (c == extra_start_at);
      if (c == extra_start_at) cfg_n_out = 5'($urandom);
      if (c == rst_at) reset = 1'b1;
      else if (c == rst_at + 1) reset = 1'b0;
      @(negedge clk);
      in_rst = (rst_at >= 0) && (c > rst_at);
      e_ren  = !in_rst && (c < 10 * n) && (c % 10 != 9);
      e_acc  = !in_rst && (c >= 1) && (c - 1 < 10 * n) && ((c - 1) % 10 != 9);
      e_wen  = !in_rst && (c >= 11) && ((c - 11) % 10 == 0) && ((c - 11) / 10 < n);
      e_busy = !in_rst && (n > 0) && (c <= 10 * n + 1);
      e_done = !in_rst && (c == ((n > 0) ? 10 * n + 2 : 0));
      check($sformatf("%s.ren@%0d", tag, c), 32'(psum_ren), 32'(e_ren));
      check($sformatf("%s.acc@%0d", tag, c), 32'(acc), 32'(e_acc));
      check($sformatf("%s.wen@%0d", tag, c), 32'(out_wen), 32'(e_wen));
      check($sformatf("%s.busy@%0d", tag, c), 32'(busy), 32'(e_busy));
      check($sformatf("%s.done@%0d", tag, c), 32'(done), 32'(e_done));
      if (e_ren)
        check($sformatf("%s.raddr@%0d", tag, c), 32'(psum_raddr), 32'(((c % 10) * n + c / 10) % 2048));
      if (e_wen)
        check($sformatf("%s.waddr@%0d", tag, c), 32'(out_waddr), 32'((c - 11) / 10));
      if (in_rst) begin
        check($sformatf("%s.rst_raddr@%0d", tag, c), 32'(psum_raddr), 32'd0);
        check($sformatf("%s.rst_waddr@%0d", tag, c), 32'(out_waddr), 32'd0);
      end
      if (out_wen === 1'b1) begin
        got[out_waddr] = sfp_out;
        wr_cnt++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    reset = 1'b0;
    if (rst_at < 0) begin
      check({tag, ".writes"}, 32'(wr_cnt), 32'(n));
      for (int o = 0; o < n; o++)
        check($sformatf("%s.out[%0d]", tag, o), 32'(got[o]), 32'(golden(n, o)));
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2048; i++) psum_mem[i] = 16'($urandom);
  endtask

  initial begin
    fill_random();
    for (int k = 0; k < 9; k++) begin
      psum_mem[k * 16 + 3] = 16'(k + 1);
      psum_mem[k * 16 + 5] = 16'hFFFE;
      psum_mem[k * 16 + 6] = (k == 0) ? 16'h7FF0 : 16'h0002;
      psum_mem[k * 16 + 7] = (k < 4) ? 16'hC000 : 16'h0010;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.ren", 32'(psum_ren), 32'd0);
    check("reset.raddr", 32'(psum_raddr), 32'd0);
    check("reset.acc", 32'(acc), 32'd0);
    check("reset.wen", 32'(out_wen), 32'd0);
    check("reset.waddr", 32'(out_waddr), 32'd0);
    check("reset.busy8", 32'(busy8), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_pass(16, -1, -1, "p16");
    check("data.taps_1_to_9", 32'(got[3]), 32'd45);
    check("data.neg_relu", 32'(got[5]), 32'd0);
    check("data.overflow_neg", 32'(got[6]), 32'd0);
    check("data.wrap_pos", 32'(got[7]), 32'd80);

    run_pass(16, 30, -1, "p16_restart");
    run_pass(16, -1, 50, "p16_reset");
    run_pass(16, -1, -1, "p16_again");
    run_pass(0, -1, -1, "p0");
    run_pass(1, -1, -1, "p1");
    fill_random();
    run_pass(int'($urandom_range(2, 31)), -1, -1, "prand");
    run_pass(31, -1, -1, "p31");

    start8 = 1'b1;
    cfg8 = 5'd31;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int c = 0; c <= 314; c++) begin
      @(negedge clk);
      if ((c < 310) && (c % 10 != 9))
        check($sformatf("a8.raddr@%0d", c), 32'(raddr8), 32'(((c % 10) * 31 + c / 10) % 256));
      if (c == 308) begin
        check("a8.wrap_ren", 32'(ren8), 32'd1);
        check("a8.wrap_raddr", 32'(raddr8), 32'd22);
      end
      check($sformatf("a8.done@%0d", c), 32'(done8), 32'(c == 312));
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
